// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle add/sub/logic/shift ops stream one per clock,
// unsigned MUL iterates one shift-add step per cycle and holds o_ready low while busy.
module alu_seq #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_alu_ctrl,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_flags,
  output logic         o_valid
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_LSL = 3'b101, OP_LSR = 3'b110, OP_MUL = 3'b111
  } op_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  typedef struct packed {
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic [CW-1:0] cnt;
  } mul_t;

  state_e state_q, state_d;
  mul_t   mul_q;
  op_e    op;
  logic   accept;
  logic   mul_last;

  assign op       = op_e'(i_alu_ctrl);
  assign accept   = i_valid && o_ready;
  assign mul_last = (mul_q.cnt == CW'(N - 1));

  // ---------------- single-cycle datapath ----------------
  logic [N-1:0] b_inv;
  logic [N:0]   sum;
  logic [N:0]   shl;
  logic [N:0]   shr;
  logic [SW-1:0] s;
  logic [N-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;

  // One adder serves ADD and SUB: ctrl[0] both inverts B and supplies the carry-in.
  assign b_inv = i_b ^ {N{i_alu_ctrl[0]}};
  assign sum   = {1'b0, i_a} + {1'b0, b_inv} + {{N{1'b0}}, i_alu_ctrl[0]};
  assign s     = i_b[SW-1:0];
  // The extra bit beyond the result catches the last bit shifted out (0 when s==0).
  assign shl   = {1'b0, i_a} << s;
  assign shr   = {i_a, 1'b0} >> s;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (i_a[N-1] == b_inv[N-1]) && (sum[N-1] != i_a[N-1]);
      end
      OP_AND: alu_res = i_a & i_b;
      OP_OR:  alu_res = i_a | i_b;
      OP_XOR: alu_res = i_a ^ i_b;
      OP_LSL: begin
        alu_res = shl[N-1:0];
        alu_c   = shl[N];
      end
      OP_LSR: begin
        alu_res = shr[N:1];
        alu_c   = shr[0];
      end
      default: alu_res = '0;
    endcase
  end

  // ---------------- multiplier step ----------------
  logic [N-1:0] acc_nxt;
  assign acc_nxt = mul_q.acc + (mul_q.mplier[0] ? mul_q.mcand : '0);

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && op == OP_MUL) state_d = ST_BUSY;
      ST_BUSY: if (mul_last)               state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE);
  end

  // ---------------- result / flag registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mul_q    <= '0;
      o_result <= '0;
      o_flags  <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mul_q.acc    <= '0;
          mul_q.mcand  <= i_a;
          mul_q.mplier <= i_b;
          mul_q.cnt    <= '0;
        end else begin
          o_result <= alu_res;
          o_flags  <= {alu_res[N-1], alu_res == '0, alu_c, alu_v};
          o_valid  <= 1'b1;
        end
      end else if (state_q == ST_BUSY) begin
        mul_q.acc    <= acc_nxt;
        mul_q.mcand  <= mul_q.mcand << 1;
        mul_q.mplier <= mul_q.mplier >> 1;
        mul_q.cnt    <= mul_q.cnt + 1'b1;
        if (mul_last) begin
          o_result <= acc_nxt;
          o_flags  <= {acc_nxt[N-1], acc_nxt == '0, 2'b00};
          o_valid  <= 1'b1;
        end
      end
    end
  end
endmodule
